// File: rtl/uart_rx_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// The receiver drives through the master modport; the byte consumer uses the slave modport.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre-sampled on a 2-FF synchronised line.
// Delivers bytes on a valid/ready register and pulses frame_err / overrun for one cycle.
module uart_rx #(
  parameter int G_CLK_FREQ = 100000000,
  parameter int G_BAUD     = 115200
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx_in,
  uart_rx_if.master rx_if
);

  localparam int C_BIT  = G_CLK_FREQ / G_BAUD;
  localparam int C_HALF = C_BIT / 2;
  localparam int CNT_W  = $clog2(C_BIT);
  localparam logic [CNT_W-1:0] C_BIT_M1  = CNT_W'(C_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(C_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             rx_p0, rx_p1;
  logic             rx_s;
  logic             byte_done;
  logic             ferr_hit;

  // Stage p0/p1: metastability synchroniser, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Shift register carries data only; the FSM decides when it is meaningful
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    byte_done   = 1'b0;
    ferr_hit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == C_HALF_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt   = S_DATA;
            bit_idx_nxt = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt == C_BIT_M1) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == C_BIT_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_hit  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output stage: a same-edge accept frees the register so back-to-back bytes survive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.data_out   <= 8'h00;
      rx_if.data_valid <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end else begin
      rx_if.frame_err <= ferr_hit;
      rx_if.overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_if.data_valid || rx_if.data_ready) begin
          rx_if.data_out   <= shift;
          rx_if.data_valid <= 1'b1;
        end else begin
          rx_if.overrun <= 1'b1;
        end
      end else if (rx_if.data_valid && rx_if.data_ready) begin
        rx_if.data_valid <= 1'b0;
      end
    end
  end

  assign rx_if.busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: normal bytes, false start,
// framing error with held-low line, overrun, back-to-back bytes and mid-frame reset.
module tb_uart_rx;
  localparam int CLK_FREQ = 1843200;
  localparam int BAUD     = 115200;
  localparam int NBIT     = 16;
  localparam int NHALF    = 8;

  logic clk;
  logic rst_n;
  logic rx_in;

  uart_rx_if u_if ();

  uart_rx #(
    .G_CLK_FREQ(CLK_FREQ),
    .G_BAUD    (BAUD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_in(rx_in),
    .rx_if(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor: logs every accepted byte and counts status pulses, sampled mid-cycle
  logic [7:0] rx_log [64];
  int rx_cnt   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  always @(negedge clk) begin
    if (u_if.data_valid && u_if.data_ready) begin
      rx_log[rx_cnt % 64] <= u_if.data_out;
      rx_cnt <= rx_cnt + 1;
    end
    if (u_if.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (u_if.overrun)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and land 2 time units after the last rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_in = frame[i];
      cyc(NBIT);
    end
  endtask

  task automatic uart_tx(input logic [7:0] b);
    send_bits({1'b1, b, 1'b0}, 10);
  endtask

  int rx0, fe0, ov0, nbusy;

  initial begin
    rx_in = 1'b1;
    rst_n = 1'b0;
    u_if.data_ready = 1'b0;
    cyc(3);
    check("rst_data_out",   {24'd0, u_if.data_out}, 32'h00);
    check("rst_data_valid", {31'd0, u_if.data_valid}, 32'd0);
    check("rst_busy",       {31'd0, u_if.busy}, 32'd0);
    rst_n = 1'b1;
    cyc(NBIT);

    // 1: single byte with a ready consumer
    u_if.data_ready = 1'b1;
    rx0 = rx_cnt; fe0 = ferr_cnt; ov0 = ovr_cnt;
    uart_tx(8'hA5);
    cyc(4);
    check("t1_count", rx_cnt - rx0, 32'd1);
    check("t1_byte",  {24'd0, rx_log[(rx_cnt - 1) % 64]}, 32'hA5);
    check("t1_ferr",  ferr_cnt - fe0, 32'd0);
    check("t1_ovr",   ovr_cnt - ov0, 32'd0);
    check("t1_valid_cleared", {31'd0, u_if.data_valid}, 32'd0);

    // 2: 4-clock glitch is rejected as a false start
    rx0 = rx_cnt; fe0 = ferr_cnt; nbusy = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (u_if.busy) nbusy++;
    end
    rx_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (u_if.busy) nbusy++;
    end
    check("t2_busy_seen",  {31'd0, (nbusy >= 1)}, 32'd1);
    check("t2_busy_bound", {31'd0, (nbusy <= NHALF + 3)}, 32'd1);
    check("t2_no_byte",    rx_cnt - rx0, 32'd0);
    check("t2_no_ferr",    ferr_cnt - fe0, 32'd0);
    check("t2_idle",       {31'd0, u_if.busy}, 32'd0);

    // 3: stop bit low, line held low, then a good byte
    rx0 = rx_cnt; fe0 = ferr_cnt;
    send_bits({1'b0, 8'h3C, 1'b0}, 10);
    rx_in = 1'b0;
    cyc(2 * NBIT);
    rx_in = 1'b1;
    cyc(NBIT);
    check("t3_ferr_once", ferr_cnt - fe0, 32'd1);
    check("t3_no_byte",   rx_cnt - rx0, 32'd0);
    check("t3_idle",      {31'd0, u_if.busy}, 32'd0);
    uart_tx(8'h55);
    cyc(4);
    check("t3_next_count", rx_cnt - rx0, 32'd1);
    check("t3_next_byte",  {24'd0, rx_log[(rx_cnt - 1) % 64]}, 32'h55);

    // 4: overrun while the first byte is unaccepted
    u_if.data_ready = 1'b0;
    rx0 = rx_cnt; ov0 = ovr_cnt;
    uart_tx(8'h11);
    uart_tx(8'h22);
    cyc(4);
    check("t4_valid_held", {31'd0, u_if.data_valid}, 32'd1);
    check("t4_data_held",  {24'd0, u_if.data_out}, 32'h11);
    check("t4_ovr_once",   ovr_cnt - ov0, 32'd1);
    u_if.data_ready = 1'b1;
    cyc(3);
    check("t4_accept_count", rx_cnt - rx0, 32'd1);
    check("t4_accept_byte",  {24'd0, rx_log[(rx_cnt - 1) % 64]}, 32'h11);
    check("t4_valid_clear",  {31'd0, u_if.data_valid}, 32'd0);

    // 5: back-to-back bytes
    rx0 = rx_cnt; fe0 = ferr_cnt; ov0 = ovr_cnt;
    uart_tx(8'h00);
    uart_tx(8'hFF);
    uart_tx(8'h80);
    cyc(4);
    check("t5_count", rx_cnt - rx0, 32'd3);
    check("t5_b0", {24'd0, rx_log[rx0 % 64]}, 32'h00);
    check("t5_b1", {24'd0, rx_log[(rx0 + 1) % 64]}, 32'hFF);
    check("t5_b2", {24'd0, rx_log[(rx0 + 2) % 64]}, 32'h80);
    check("t5_errs", (ferr_cnt - fe0) + (ovr_cnt - ov0), 32'd0);

    // 6: reset during bit 4 of 0x96, then a clean 0x96
    send_bits({1'b1, 8'h96, 1'b0}, 5);
    rx_in = 1'b1;
    cyc(NHALF);
    check("t6_busy_before", {31'd0, u_if.busy}, 32'd1);
    rst_n = 1'b0;
    cyc(2);
    check("t6_rst_data_out",  {24'd0, u_if.data_out}, 32'h00);
    check("t6_rst_valid",     {31'd0, u_if.data_valid}, 32'd0);
    check("t6_rst_frame_err", {31'd0, u_if.frame_err}, 32'd0);
    check("t6_rst_overrun",   {31'd0, u_if.overrun}, 32'd0);
    check("t6_rst_busy",      {31'd0, u_if.busy}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10 * NBIT);
    rx0 = rx_cnt;
    uart_tx(8'h96);
    cyc(4);
    check("t6_count", rx_cnt - rx0, 32'd1);
    check("t6_byte",  {24'd0, rx_log[(rx_cnt - 1) % 64]}, 32'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
